// File: rtl/munoc_axi_apb_bridge.sv
// munoc_axi_apb_bridge: AXI4 slave port to APB master.
// Every AXI beat becomes one APB transfer. Only one transaction is in flight.
// The B and R responses come back on the NI response channels.
module munoc_axi_apb_bridge #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // AXI write address
    input  logic [BW_AXI_TID-1:0]   sxawid,
    input  logic [BW_ADDR-1:0]      sxawaddr,
    input  logic [7:0]              sxawlen,
    input  logic [2:0]              sxawsize,
    input  logic [1:0]              sxawburst,
    input  logic                    sxawvalid,
    output logic                    sxawready,
    // AXI write data
    input  logic [BW_DATA-1:0]      sxwdata,
    input  logic [BW_DATA/8-1:0]    sxwstrb,
    input  logic                    sxwlast,
    input  logic                    sxwvalid,
    output logic                    sxwready,
    // AXI write response
    output logic [BW_AXI_TID-1:0]   sxbid,
    output logic [1:0]              sxbresp,
    output logic                    sxbvalid,
    input  logic                    sxbready,
    // AXI read address
    input  logic [BW_AXI_TID-1:0]   sxarid,
    input  logic [BW_ADDR-1:0]      sxaraddr,
    input  logic [7:0]              sxarlen,
    input  logic [2:0]              sxarsize,
    input  logic [1:0]              sxarburst,
    input  logic                    sxarvalid,
    output logic                    sxarready,
    // AXI read data
    output logic [BW_AXI_TID-1:0]   sxrid,
    output logic [BW_DATA-1:0]      sxrdata,
    output logic [1:0]              sxrresp,
    output logic                    sxrlast,
    output logic                    sxrvalid,
    input  logic                    sxrready,
    // APB master
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [BW_ADDR-1:0]      paddr,
    output logic [BW_DATA-1:0]      pwdata,
    output logic [BW_DATA/8-1:0]    pstrb,
    input  logic [BW_DATA-1:0]      prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_W = BW_DATA / 8;

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP} state_t;

    state_t                  state_reg;
    logic [BW_AXI_TID-1:0]   id_reg;
    logic [BW_ADDR-1:0]      addr_reg;
    logic [7:0]              len_reg;
    logic [2:0]              size_reg;
    logic [1:0]              burst_reg;
    logic [7:0]              cnt_reg;
    logic                    err_reg;
    logic                    write_reg;
    logic                    prio_wr_reg;
    logic [BW_DATA-1:0]      wdata_reg;
    logic [STRB_W-1:0]       strb_reg;
    logic [BW_DATA-1:0]      rdata_reg;

    logic                    wr_gnt;
    logic                    rd_gnt;
    logic                    last_beat;
    logic [BW_ADDR-1:0]      incr_addr;
    logic [BW_ADDR-1:0]      wrap_mask;
    logic [BW_ADDR-1:0]      addr_next;

    // sxwlast is ignored: the beat counter decides the final write beat
    logic unused_ok;
    assign unused_ok = &{1'b0, sxwlast};

    // Grant depends on state and valids only; ties alternate, write first after reset
    assign wr_gnt = (state_reg == IDLE) && sxawvalid && (!sxarvalid || prio_wr_reg);
    assign rd_gnt = (state_reg == IDLE) && sxarvalid && (!sxawvalid || !prio_wr_reg);

    assign last_beat = (cnt_reg == len_reg);
    assign incr_addr = addr_reg + (BW_ADDR'(1) << size_reg);
    assign wrap_mask = ((BW_ADDR'(len_reg) + BW_ADDR'(1)) << size_reg) - BW_ADDR'(1);

    // Next beat address; reserved burst type behaves like INCR
    always_comb begin
        addr_next = incr_addr;
        case (burst_reg)
            2'b00:   addr_next = addr_reg;
            2'b10:   addr_next = (addr_reg & ~wrap_mask) | (incr_addr & wrap_mask);
            default: addr_next = incr_addr;
        endcase
    end

    // Outputs are decoded from registered state and latched fields
    assign sxawready = wr_gnt;
    assign sxarready = rd_gnt;
    assign sxwready  = (state_reg == WDATA);
    assign sxbvalid  = (state_reg == BRESP);
    assign sxbid     = id_reg;
    assign sxbresp   = (state_reg == BRESP && err_reg) ? 2'b10 : 2'b00;
    assign sxrvalid  = (state_reg == RDATA);
    assign sxrid     = id_reg;
    assign sxrdata   = rdata_reg;
    assign sxrresp   = (state_reg == RDATA && err_reg) ? 2'b10 : 2'b00;
    assign sxrlast   = (state_reg == RDATA) && last_beat;
    assign psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign penable   = (state_reg == ACCESS);
    assign pwrite    = write_reg;
    assign paddr     = addr_reg & ~BW_ADDR'(STRB_W - 1);
    assign pwdata    = wdata_reg;
    assign pstrb     = write_reg ? strb_reg : '0;

    // Bridge FSM: accept a request, run one APB transfer per beat, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            write_reg   <= 1'b0;
            prio_wr_reg <= 1'b1;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_gnt) begin
                        id_reg    <= sxawid;
                        addr_reg  <= sxawaddr;
                        len_reg   <= sxawlen;
                        size_reg  <= sxawsize;
                        burst_reg <= sxawburst;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        write_reg <= 1'b1;
                        state_reg <= WDATA;
                        if (sxarvalid) prio_wr_reg <= 1'b0;
                    end else if (rd_gnt) begin
                        id_reg    <= sxarid;
                        addr_reg  <= sxaraddr;
                        len_reg   <= sxarlen;
                        size_reg  <= sxarsize;
                        burst_reg <= sxarburst;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        write_reg <= 1'b0;
                        state_reg <= SETUP;
                        if (sxawvalid) prio_wr_reg <= 1'b1;
                    end
                end
                WDATA: begin
                    if (sxwvalid) begin
                        wdata_reg <= sxwdata;
                        strb_reg  <= sxwstrb;
                        state_reg <= SETUP;
                    end
                end
                SETUP: state_reg <= ACCESS;
                ACCESS: begin
                    if (pready) begin
                        if (write_reg) begin
                            err_reg <= err_reg | pslverr;
                            if (last_beat) begin
                                state_reg <= BRESP;
                            end else begin
                                cnt_reg   <= cnt_reg + 8'd1;
                                addr_reg  <= addr_next;
                                state_reg <= WDATA;
                            end
                        end else begin
                            rdata_reg <= prdata;
                            err_reg   <= pslverr;
                            state_reg <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (sxrready) begin
                        if (last_beat) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg   <= cnt_reg + 8'd1;
                            addr_reg  <= addr_next;
                            state_reg <= SETUP;
                        end
                    end
                end
                BRESP: begin
                    if (sxbready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_munoc_axi_apb_bridge.sv
// Directed testbench for munoc_axi_apb_bridge.
module tb_munoc_axi_apb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sxawid, sxarid, sxbid, sxrid;
    logic [31:0] sxawaddr, sxaraddr;
    logic [7:0]  sxawlen, sxarlen;
    logic [2:0]  sxawsize, sxarsize;
    logic [1:0]  sxawburst, sxarburst, sxbresp, sxrresp;
    logic        sxawvalid, sxawready, sxarvalid, sxarready;
    logic [31:0] sxwdata, sxrdata;
    logic [3:0]  sxwstrb;
    logic        sxwlast, sxwvalid, sxwready;
    logic        sxbvalid, sxbready;
    logic        sxrlast, sxrvalid, sxrready;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_addr [4];

    munoc_axi_apb_bridge dut (
        .clk(clk), .rst(rst),
        .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
        .sxawburst(sxawburst), .sxawvalid(sxawvalid), .sxawready(sxawready),
        .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast), .sxwvalid(sxwvalid),
        .sxwready(sxwready),
        .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
        .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
        .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
        .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
        .sxrvalid(sxrvalid), .sxrready(sxrready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    wire [120:0] all_out = {sxawready, sxarready, sxwready, sxbid, sxbresp, sxbvalid,
                            sxrid, sxrdata, sxrresp, sxrlast, sxrvalid,
                            psel, penable, pwrite, paddr, pwdata, pstrb};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One read burst; paddr per beat from exp_addr, prdata = 0x10 + beat
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst);
        sxarid = id; sxaraddr = addr; sxarlen = len; sxarsize = 3'd2;
        sxarburst = burst; sxarvalid = 1'b1;
        #1;
        chk("rd_arready", sxarready, 1'b1);
        cyc();
        sxarvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            chk("rd_setup_psel", {psel, penable, pwrite}, 3'b100);
            chk("rd_paddr", paddr, exp_addr[b]);
            chk("rd_pstrb", pstrb, 4'h0);
            prdata = 32'h10 + 32'(b);
            pready = 1'b1;
            cyc();
            chk("rd_access", {psel, penable, sxrvalid}, 3'b110);
            cyc();
            pready = 1'b0;
            chk("rd_rvalid", {sxrvalid, psel}, 2'b10);
            chk("rd_rdata", sxrdata, 32'h10 + 32'(b));
            chk("rd_rlast", sxrlast, (b == int'(len)));
            chk("rd_rid_resp", {sxrid, sxrresp}, {id, 2'b00});
            sxrready = 1'b1;
            cyc();
            sxrready = 1'b0;
        end
        chk("rd_done", {sxrvalid, psel}, 2'b00);
        $display("txn read addr=%0h len=%0d burst=%0d", addr, len, burst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic grants [3];
        int ng;
        rst = 1'b1;
        sxawid = '0; sxawaddr = '0; sxawlen = '0; sxawsize = '0; sxawburst = '0; sxawvalid = 1'b0;
        sxarid = '0; sxaraddr = '0; sxarlen = '0; sxarsize = '0; sxarburst = '0; sxarvalid = 1'b0;
        sxwdata = '0; sxwstrb = '0; sxwlast = 1'b0; sxwvalid = 1'b0;
        sxbready = 1'b0; sxrready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        cyc(); cyc();
        chk("reset_outputs", all_out, 121'd0);
        rst = 1'b0;
        cyc();

        // Single write: AW at cycle 0, W at cycle 1
        sxawid = 4'd5; sxawaddr = 32'h100; sxawlen = 8'd0; sxawsize = 3'd2;
        sxawburst = 2'b01; sxawvalid = 1'b1;
        #1;
        chk("wr_grant", {sxawready, sxarready}, 2'b10);
        cyc();
        sxawvalid = 1'b0;
        chk("wr_wdata_state", {sxwready, psel}, 2'b10);
        sxwdata = 32'hDEADBEEF; sxwstrb = 4'hF; sxwlast = 1'b1; sxwvalid = 1'b1;
        cyc();
        sxwvalid = 1'b0;
        chk("wr_setup", {psel, penable, pwrite}, 3'b101);
        chk("wr_paddr", paddr, 32'h100);
        chk("wr_pwdata", pwdata, 32'hDEADBEEF);
        chk("wr_pstrb", pstrb, 4'hF);
        pready = 1'b1;
        cyc();
        chk("wr_access", {psel, penable}, 2'b11);
        cyc();
        pready = 1'b0;
        chk("wr_bvalid", {sxbvalid, psel}, 2'b10);
        chk("wr_bid_resp", {sxbid, sxbresp}, {4'd5, 2'b00});
        sxbready = 1'b1;
        cyc();
        sxbready = 1'b0;
        chk("wr_done", sxbvalid, 1'b0);
        $display("txn write addr=100 data=deadbeef");

        // INCR read burst
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h204; exp_addr[2] = 32'h208; exp_addr[3] = 32'h20C;
        read_burst(4'd3, 32'h200, 8'd3, 2'b01);

        // WRAP read burst
        exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
        read_burst(4'd7, 32'h38, 8'd3, 2'b10);

        // Two-beat write, slave error on beat 0 only
        sxawid = 4'd9; sxawaddr = 32'h300; sxawlen = 8'd1; sxawsize = 3'd2;
        sxawburst = 2'b01; sxawvalid = 1'b1;
        cyc();
        sxawvalid = 1'b0;
        sxwdata = 32'hA0; sxwstrb = 4'h3; sxwvalid = 1'b1;
        cyc();
        sxwvalid = 1'b0;
        chk("err_paddr0", paddr, 32'h300);
        pready = 1'b1; pslverr = 1'b1;
        cyc();
        cyc();
        pready = 1'b0; pslverr = 1'b0;
        chk("err_between_beats", {sxwready, psel, sxbvalid}, 3'b100);
        sxwdata = 32'hA1; sxwstrb = 4'hC; sxwvalid = 1'b1;
        cyc();
        sxwvalid = 1'b0;
        chk("err_paddr1", paddr, 32'h304);
        chk("err_pwdata1", {pwdata, pstrb}, {32'hA1, 4'hC});
        pready = 1'b1;
        cyc();
        cyc();
        pready = 1'b0;
        chk("err_bresp", {sxbvalid, sxbid, sxbresp}, {1'b1, 4'd9, 2'b10});
        sxbready = 1'b1;
        cyc();
        sxbready = 1'b0;
        $display("txn write addr=300 len=1 slverr on beat0");

        // Read with pready low for 5 ACCESS cycles
        sxarid = 4'd2; sxaraddr = 32'h400; sxarlen = 8'd0; sxarburst = 2'b01; sxarvalid = 1'b1;
        cyc();
        sxarvalid = 1'b0;
        pready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_wait", {psel, penable, sxrvalid}, 3'b110);
            cyc();
        end
        chk("bp_last_access", {psel, penable, sxrvalid}, 3'b110);
        prdata = 32'hCAFE0001; pready = 1'b1;
        cyc();
        pready = 1'b0;
        chk("bp_rdata", {sxrvalid, sxrlast, sxrdata}, {2'b11, 32'hCAFE0001});
        sxrready = 1'b1;
        cyc();
        sxrready = 1'b0;
        $display("txn read addr=400 with 5 wait states");

        // Arbitration: both requests held from reset
        rst = 1'b1;
        sxawaddr = 32'h500; sxawlen = 8'd0; sxawvalid = 1'b1;
        sxaraddr = 32'h600; sxarlen = 8'd0; sxarvalid = 1'b1;
        sxwvalid = 1'b1; pready = 1'b1; sxbready = 1'b1; sxrready = 1'b1;
        cyc();
        rst = 1'b0;
        ng = 0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            if (sxawready || sxarready) begin
                grants[ng] = sxawready;
                ng++;
            end
            cyc();
        end
        chk("arb_count", 32'(ng), 32'd3);
        if (ng == 3) begin
            chk("arb_first", grants[0], 1'b1);
            chk("arb_second", grants[1], 1'b0);
            chk("arb_third", grants[2], 1'b1);
        end
        $display("txn arbitration grants=%0d", ng);
        sxawvalid = 1'b0; sxarvalid = 1'b0; sxwvalid = 1'b0;
        pready = 1'b0; sxbready = 1'b0; sxrready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        // Reset during ACCESS of the third beat of a 4-beat read
        sxarid = 4'd4; sxaraddr = 32'h700; sxarlen = 8'd3; sxarburst = 2'b01; sxarvalid = 1'b1;
        cyc();
        sxarvalid = 1'b0;
        sxrready = 1'b1; pready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            cyc(); cyc(); cyc();
        end
        pready = 1'b0;
        chk("mid_setup_beat2", {psel, penable, paddr}, {2'b10, 32'h708});
        cyc();
        chk("mid_access_beat2", {psel, penable}, 2'b11);
        rst = 1'b1;
        sxrready = 1'b0;
        cyc();
        chk("mid_reset_outputs", all_out, 121'd0);
        rst = 1'b0;
        cyc();
        $display("txn read aborted by reset");
        exp_addr[0] = 32'h600;
        read_burst(4'd1, 32'h600, 8'd0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
